fifo_wptr_full: RTL
===================

// Module: fifo_wptr_full
// PURPOSE
//  - Write-domain pointer and status generator for the asynchronous FIFO.
//  - Keeps the binary/Gray write pointer and drives the dual-port RAM write address and enable.
//  - Publishes a registered Gray write pointer for the two-flop synchronizer into the read domain.
//  - Consumes the read pointer after it has been synchronized into the write domain, and from it
//    derives full, almost_full, a fill level and a sticky overflow flag.
// PARAMETERS
//  ADDR_WIDTH    4    RAM address bits; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  AFULL_THRESH  12   almost_full asserts when wr_level >= AFULL_THRESH (range 1..DEPTH)
// PORTS
//  clk             in   1             write-domain clock
//  rst_n           in   1             asynchronous active-low reset
//  wr_en           in   1             write request from producer
//  clr_ovf         in   1             clear sticky overflow flag
//  rptr_gray_sync  in   ADDR_WIDTH+1  Gray read pointer, already synchronized into clk domain
//  wptr_gray       out  ADDR_WIDTH+1  registered Gray write pointer, goes to the read-domain synchronizer
//  waddr           out  ADDR_WIDTH    RAM write address = wbin[ADDR_WIDTH-1:0]
//  mem_we          out  1             RAM write enable = wr_en & ~full & rst_n (combinational)
//  full            out  1             registered full flag
//  almost_full     out  1             registered almost-full flag
//  wr_level        out  ADDR_WIDTH+1  registered occupancy seen from write side, 0..DEPTH
//  overflow        out  1             sticky: a write was attempted while full
// BEHAVIOUR
//  - Reset (async, rst_n=0): wbin, wptr_gray, full, almost_full, wr_level and overflow all clear to 0.
//    Because waddr is derived from wbin, it is 0 during reset; mem_we is forced to 0 while rst_n=0.
//  - Registered state is wbin[ADDR_WIDTH:0] and wptr_gray. No FSM; all updates happen on posedge clk.
//  - Write accepted when wr_en & ~full.
//    - wbin_next = wbin + accepted, modulo 2**(ADDR_WIDTH+1); wraps naturally.
//    - wgray_next = (wbin_next >> 1) ^ wbin_next; wptr_gray <= wgray_next.
//  - Full detection:
//    - full <= (wgray_next == {~rptr_gray_sync[AW:AW-1], rptr_gray_sync[AW-2:0]}), AW = ADDR_WIDTH.
//    - full rises on the same edge that accepts the DEPTH-th unread word, so there is no extra latency.
//    - full falls on the first edge after rptr_gray_sync shows a read; it is pessimistic by the
//      synchronizer latency (2 clk) and never optimistic.
//  - Level:
//    - rbin = Gray-to-binary of rptr_gray_sync (XOR prefix from the MSB down).
//    - wr_level <= wbin_next - rbin, modulo 2**(ADDR_WIDTH+1). It never exceeds DEPTH for a legal read side.
//    - almost_full <= (wbin_next - rbin) >= AFULL_THRESH. It updates on the same edge as wr_level.
//  - Overflow:
//    - Set when wr_en & full on a clk edge. The write is dropped and the pointer holds.
//    - Cleared when clr_ovf=1. If set and clear occur together, set wins.
//  - Gray invariant: wptr_gray changes by at most one bit per clk and changes only on an accepted write.
//  - wr_en while full: mem_we=0, wbin, wptr_gray and waddr unchanged, full stays 1.
//  - rptr_gray_sync changing on the same edge as a write: both are folded into full and level on that edge.
//  - Reset mid-burst: outputs return to the reset values immediately, with no clock required.
//    Operation resumes from address 0 on the first edge after rst_n deasserts.
// TESTING (ADDR_WIDTH=4, AFULL_THRESH=12, DEPTH=16)
//  1. Reset:
//     - Stimulus: assert rst_n=0, then release.
//     - Required: wptr_gray=0, waddr=0, full=0, almost_full=0, wr_level=0, overflow=0, mem_we=0 during reset.
//  2. Fill:
//     - Stimulus: 16 back-to-back writes with rptr_gray_sync=0.
//     - Required: almost_full=1 after the 12th edge; full=1, wr_level=16 and wptr_gray=5'b11000 after the 16th.
//  3. Overflow:
//     - Stimulus: a 17th write while full.
//     - Required: mem_we=0; wptr_gray holds at 5'b11000; overflow=1 next edge; clr_ovf=1 -> overflow=0.
//  4. Drain seen:
//     - Stimulus: rptr_gray_sync set to 5'b00110 (binary 4).
//     - Required: full=0, wr_level=12 and almost_full=1 next edge; rptr set to binary 5 -> almost_full=0.
//  5. Wrap:
//     - Stimulus: 40 writes with a model reader keeping level < 16.
//     - Required: waddr goes 15->0; wptr_gray goes 5'b10000 -> 5'b00000 at binary 31->0;
//       exactly one bit flips per accepted write.
//  6. Async reset:
//     - Stimulus: pull rst_n low mid-burst, between clk edges.
//     - Required: all outputs are 0 before the next edge; after release the first write goes to waddr=0.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, RAM write control and full/almost-full/level/overflow status for an
// asynchronous FIFO; the read pointer arrives already synchronized into this clock domain.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  clr_ovf,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  mem_we,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return {1'b0, b[PW-1:1]} ^ b;
  endfunction

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] rgray_full_s;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          accept_s;

  // Next-state for pointers and status; full compares against the read pointer one lap behind
  always_comb begin
    accept_s     = wr_en & ~full_q;
    wbin_d       = wbin_q + {{ADDR_WIDTH{1'b0}}, accept_s};
    wgray_d      = bin2gray(wbin_d);
    rbin_s       = gray2bin(rptr_gray_sync);
    level_d      = wbin_d - rbin_s;
    rgray_full_s = {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_sync[ADDR_WIDTH-2:0]};
    full_d       = (wgray_d == rgray_full_s);
    afull_d      = (level_d >= AFULL_T);
    if (wr_en & full_q) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= {PW{1'b0}};
      wgray_q <= {PW{1'b0}};
      level_q <= {PW{1'b0}};
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  // Write enable is gated by rst_n so the RAM sees no write while reset is held
  assign mem_we      = accept_s & rst_n;
  assign waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule
